// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl -- load/store unit to data-memory request controller
//
// Accepts one load or store at a time from the core, issues a single
// request/grant transaction to data memory, and returns a sign/zero extended
// load result. Four-state FSM: IDLE -> REQ -> (WAIT_R) -> DONE -> IDLE.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : a misaligned access is trapped in IDLE (one-cycle misalign_err
//               pulse, no memory request, no stall).
//   undefined : misalign_err is tied low; a misaligned access is issued with
//               its address truncated to natural alignment.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   mem_read          load request from decode
//   mem_write         store request from decode (wins over mem_read)
//   mem_load_type     LB=000 LH=001 LW=010 LBU=011 LHU=100 DEF=111
//   mem_store_type    SB=00 SH=01 SW=10 DEF=11
//   addr              byte address
//   store_data        store value in the low lanes
//   load_data         extended load result, held until the next load completes
//   lsu_stall         core holds its inputs while high
//   lsu_done          one-cycle completion pulse
//   misalign_err      one-cycle misalignment pulse (trap build only)
//   dmem_req/we/addr/wstrb/wdata   memory request (addr word aligned)
//   dmem_gnt          request accepted
//   dmem_rvalid       read data valid
//   dmem_rdata        read word
// -----------------------------------------------------------------------------
module lsu_mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  mem_load_type,
   input  logic [1:0]  mem_store_type,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        lsu_stall,
   output logic        lsu_done,
   output logic        misalign_err,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_wstrb,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata
);

   localparam logic [2:0] LD_LB  = 3'b000;
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LW  = 3'b010;
   localparam logic [2:0] LD_LBU = 3'b011;
   localparam logic [2:0] LD_LHU = 3'b100;

   localparam logic [1:0] ST_SB  = 2'b00;
   localparam logic [1:0] ST_SH  = 2'b01;
   localparam logic [1:0] ST_SW  = 2'b10;
   localparam logic [1:0] ST_DEF = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      REQ    = 2'b01,
      WAIT_R = 2'b10,
      DONE   = 2'b11
   } state_t;

   state_t      state_reg;
   logic [31:0] addr_reg;
   logic        we_reg;
   logic [2:0]  load_type_reg;
   logic [3:0]  wstrb_reg;
   logic [31:0] wdata_reg;
   logic [31:0] load_data_reg;

   // ---------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------
   logic        store_valid;
   logic        load_valid;
   logic        access_valid;
   logic        is_half;
   logic        is_word;
   logic        accept;
   logic [31:0] aligned_addr;
   logic [3:0]  wstrb_next;
   logic [31:0] wdata_next;

   always_comb begin
      store_valid = mem_write && (mem_store_type != ST_DEF);
      load_valid  = 1'b0;
      // Unlisted load encodings are treated like DEF and ignored.
      if (mem_read && !mem_write) begin
         case (mem_load_type)
            LD_LB, LD_LH, LD_LW, LD_LBU, LD_LHU: load_valid = 1'b1;
            default:                             load_valid = 1'b0;
         endcase
      end
      access_valid = store_valid || load_valid;

      if (store_valid) begin
         is_half = (mem_store_type == ST_SH);
         is_word = (mem_store_type == ST_SW);
      end else begin
         is_half = (mem_load_type == LD_LH) || (mem_load_type == LD_LHU);
         is_word = (mem_load_type == LD_LW);
      end

      // Natural alignment. In the trap build only aligned accesses are
      // accepted, so this truncation is a no-op there.
      aligned_addr = addr;
      if (is_word) begin
         aligned_addr[1:0] = 2'b00;
      end else if (is_half) begin
         aligned_addr[0] = 1'b0;
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic misaligned;
   logic misalign_err_reg;

   always_comb begin
      misaligned = access_valid &&
                   ((is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00)));
      accept     = access_valid && !misaligned;
   end
`else
   always_comb begin
      accept = access_valid;
   end
`endif

   // Byte enables and lane-replicated write data, computed at acceptance so
   // the memory-side outputs come straight from registers in REQ.
   always_comb begin
      wstrb_next = 4'b0000;
      wdata_next = 32'h0000_0000;
      if (store_valid) begin
         case (mem_store_type)
            ST_SB: begin
               wstrb_next = 4'b0001 << aligned_addr[1:0];
               wdata_next = {4{store_data[7:0]}};
            end
            ST_SH: begin
               wstrb_next = 4'b0011 << {aligned_addr[1], 1'b0};
               wdata_next = {2{store_data[15:0]}};
            end
            ST_SW: begin
               wstrb_next = 4'b1111;
               wdata_next = store_data;
            end
            default: begin
               wstrb_next = 4'b0000;
               wdata_next = 32'h0000_0000;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Load lane extraction and extension
   // ---------------------------------------------------------------
   function automatic logic [31:0] extend_load(input logic [2:0]  lt,
                                               input logic [1:0]  off,
                                               input logic [31:0] word);
      logic [7:0]  lane_b;
      logic [15:0] lane_h;
      case (off)
         2'b00:   lane_b = word[7:0];
         2'b01:   lane_b = word[15:8];
         2'b10:   lane_b = word[23:16];
         default: lane_b = word[31:24];
      endcase
      lane_h = off[1] ? word[31:16] : word[15:0];
      case (lt)
         LD_LB:   extend_load = {{24{lane_b[7]}}, lane_b};
         LD_LBU:  extend_load = {24'h000000, lane_b};
         LD_LH:   extend_load = {{16{lane_h[15]}}, lane_h};
         LD_LHU:  extend_load = {16'h0000, lane_h};
         default: extend_load = word;
      endcase
   endfunction

   // ---------------------------------------------------------------
   // FSM and datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg        <= IDLE;
         addr_reg         <= 32'h0000_0000;
         we_reg           <= 1'b0;
         load_type_reg    <= 3'b000;
         wstrb_reg        <= 4'b0000;
         wdata_reg        <= 32'h0000_0000;
         load_data_reg    <= 32'h0000_0000;
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_err_reg <= 1'b0;
`endif
      end else begin
`ifdef LSU_MISALIGN_TRAP_EN
         misalign_err_reg <= 1'b0;
`endif
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  addr_reg      <= aligned_addr;
                  we_reg        <= store_valid;
                  load_type_reg <= mem_load_type;
                  wstrb_reg     <= wstrb_next;
                  wdata_reg     <= wdata_next;
                  state_reg     <= REQ;
               end
`ifdef LSU_MISALIGN_TRAP_EN
               else if (misaligned) begin
                  misalign_err_reg <= 1'b1;
               end
`endif
            end
            REQ: begin
               // rvalid is not looked at here, so a response coincident
               // with the grant is dropped.
               if (dmem_gnt) begin
                  state_reg <= we_reg ? DONE : WAIT_R;
               end
            end
            WAIT_R: begin
               if (dmem_rvalid) begin
                  load_data_reg <= extend_load(load_type_reg, addr_reg[1:0],
                                               dmem_rdata);
                  state_reg     <= DONE;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   // Stall is combinational in IDLE so the core freezes in the acceptance
   // cycle; reset forces it low.
   assign lsu_stall  = !rst && (((state_reg == IDLE) && accept) ||
                                (state_reg == REQ) || (state_reg == WAIT_R));
   assign lsu_done   = (state_reg == DONE);
   assign load_data  = load_data_reg;

   // Memory-side fields are zero whenever no request is outstanding.
   assign dmem_req   = (state_reg == REQ);
   assign dmem_we    = dmem_req && we_reg;
   assign dmem_addr  = dmem_req ? {addr_reg[31:2], 2'b00} : 32'h0000_0000;
   assign dmem_wstrb = dmem_req ? wstrb_reg : 4'b0000;
   assign dmem_wdata = dmem_req ? wdata_reg : 32'h0000_0000;

`ifdef LSU_MISALIGN_TRAP_EN
   assign misalign_err = misalign_err_reg;
`else
   assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl -- directed self-checking bench for lsu_mem_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked there
// or 1 unit later for combinational paths. Memory responses are driven by hand.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  mem_load_type;
   logic [1:0]  mem_store_type;
   logic [31:0] addr;
   logic [31:0] store_data;
   logic [31:0] load_data;
   logic        lsu_stall;
   logic        lsu_done;
   logic        misalign_err;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;

   int vectors    = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .mem_load_type (mem_load_type),
      .mem_store_type(mem_store_type),
      .addr          (addr),
      .store_data    (store_data),
      .load_data     (load_data),
      .lsu_stall     (lsu_stall),
      .lsu_done      (lsu_done),
      .misalign_err  (misalign_err),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wstrb    (dmem_wstrb),
      .dmem_wdata    (dmem_wdata),
      .dmem_gnt      (dmem_gnt),
      .dmem_rvalid   (dmem_rvalid),
      .dmem_rdata    (dmem_rdata)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_load_type  = 3'b111;
      mem_store_type = 2'b11;
      addr           = 32'h0;
      store_data     = 32'h0;
      dmem_gnt       = 1'b0;
      dmem_rvalid    = 1'b0;
      dmem_rdata     = 32'h0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle_inputs();
      tick();
      tick();
      vectors++; if (load_data !== 32'h0) begin miscompares++; $display("FAIL rst_load_data: got %h expected %h", load_data, 32'h0); end
      vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b expected 0", lsu_stall); end
      vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", lsu_done); end
      vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL rst_misalign: got %b expected 0", misalign_err); end
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", dmem_req); end
      vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we: got %b expected 0", dmem_we); end
      vectors++; if (dmem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h expected 0", dmem_addr); end
      vectors++; if (dmem_wstrb !== 4'h0) begin miscompares++; $display("FAIL rst_wstrb: got %b expected 0000", dmem_wstrb); end
      vectors++; if (dmem_wdata !== 32'h0) begin miscompares++; $display("FAIL rst_wdata: got %h expected 0", dmem_wdata); end
      rst = 1'b0;
      tick();
      $display("txn reset: outputs checked");
   endtask

   task automatic test_sw;
      mem_write = 1'b1; mem_store_type = 2'b10; addr = 32'h100;
      store_data = 32'hDEADBEEF; dmem_gnt = 1'b1;
      #1;
      vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL sw_stall_accept: got %b expected 1", lsu_stall); end
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL sw_req_accept: got %b expected 0", dmem_req); end
      tick(); // cycle 1: REQ
      vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL sw_req: got %b expected 1", dmem_req); end
      vectors++; if (dmem_we !== 1'b1) begin miscompares++; $display("FAIL sw_we: got %b expected 1", dmem_we); end
      vectors++; if (dmem_addr !== 32'h100) begin miscompares++; $display("FAIL sw_addr: got %h expected 00000100", dmem_addr); end
      vectors++; if (dmem_wstrb !== 4'b1111) begin miscompares++; $display("FAIL sw_wstrb: got %b expected 1111", dmem_wstrb); end
      vectors++; if (dmem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL sw_wdata: got %h expected deadbeef", dmem_wdata); end
      vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("FAIL sw_done_early: got %b expected 0", lsu_done); end
      tick(); // cycle 2: DONE
      vectors++; if (lsu_done !== 1'b1) begin miscompares++; $display("FAIL sw_done: got %b expected 1", lsu_done); end
      vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL sw_stall_done: got %b expected 0", lsu_stall); end
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL sw_req_done: got %b expected 0", dmem_req); end
      idle_inputs();
      tick();
      vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("FAIL sw_done_pulse: got %b expected 0", lsu_done); end
      $display("txn SW addr=00000100 data=deadbeef");
   endtask

   task automatic test_def_ignored;
      mem_write = 1'b1; mem_store_type = 2'b11; mem_read = 1'b1;
      mem_load_type = 3'b010; addr = 32'h40; dmem_gnt = 1'b1;
      #1;
      vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL def_stall: got %b expected 0", lsu_stall); end
      tick();
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL def_req: got %b expected 0", dmem_req); end
      vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL def_stall_held: got %b expected 0", lsu_stall); end
      idle_inputs();
      tick();
      $display("txn store DEF ignored");
   endtask

   task automatic test_sb_sh;
      // SB to the top byte lane; upper store_data bits must not leak.
      mem_write = 1'b1; mem_store_type = 2'b00; addr = 32'h103;
      store_data = 32'h1234565A; dmem_gnt = 1'b1;
      tick();
      vectors++; if (dmem_wstrb !== 4'b1000) begin miscompares++; $display("FAIL sb_wstrb: got %b expected 1000", dmem_wstrb); end
      vectors++; if (dmem_wdata !== 32'h5A5A5A5A) begin miscompares++; $display("FAIL sb_wdata: got %h expected 5a5a5a5a", dmem_wdata); end
      vectors++; if (dmem_addr !== 32'h100) begin miscompares++; $display("FAIL sb_addr: got %h expected 00000100", dmem_addr); end
      tick();
      idle_inputs();
      tick();
      $display("txn SB addr=00000103 data=5a");
      // SH to the upper halfword.
      mem_write = 1'b1; mem_store_type = 2'b01; addr = 32'h102;
      store_data = 32'h1111BEEF; dmem_gnt = 1'b1;
      tick();
      vectors++; if (dmem_wstrb !== 4'b1100) begin miscompares++; $display("FAIL sh_wstrb: got %b expected 1100", dmem_wstrb); end
      vectors++; if (dmem_wdata !== 32'hBEEFBEEF) begin miscompares++; $display("FAIL sh_wdata: got %h expected beefbeef", dmem_wdata); end
      tick();
      idle_inputs();
      tick();
      $display("txn SH addr=00000102 data=beef");
   endtask

   task automatic test_lb_lbu;
      logic [2:0]  lt;
      logic [31:0] expv;
      for (int i = 0; i < 2; i++) begin
         lt   = (i == 0) ? 3'b000 : 3'b011;
         expv = (i == 0) ? 32'hFFFFFF80 : 32'h00000080;
         mem_read = 1'b1; mem_load_type = lt; addr = 32'h102; dmem_gnt = 1'b1;
         #1;
         vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL lb%0d_stall_accept: got %b expected 1", i, lsu_stall); end
         tick(); // REQ; a response coincident with the grant must be dropped
         vectors++; if (dmem_req !== 1'b1) begin miscompares++; $display("FAIL lb%0d_req: got %b expected 1", i, dmem_req); end
         vectors++; if (dmem_we !== 1'b0) begin miscompares++; $display("FAIL lb%0d_we: got %b expected 0", i, dmem_we); end
         vectors++; if (dmem_wstrb !== 4'b0000) begin miscompares++; $display("FAIL lb%0d_wstrb: got %b expected 0000", i, dmem_wstrb); end
         vectors++; if (dmem_addr !== 32'h100) begin miscompares++; $display("FAIL lb%0d_addr: got %h expected 00000100", i, dmem_addr); end
         dmem_rvalid = 1'b1; dmem_rdata = 32'h00110000;
         tick(); // WAIT_R
         vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL lb%0d_stall_wait: got %b expected 1", i, lsu_stall); end
         vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("FAIL lb%0d_done_early: got %b expected 0", i, lsu_done); end
         dmem_gnt = 1'b0; dmem_rdata = 32'h00800000;
         tick(); // DONE, cycle 3 after acceptance
         vectors++; if (lsu_done !== 1'b1) begin miscompares++; $display("FAIL lb%0d_done: got %b expected 1", i, lsu_done); end
         vectors++; if (load_data !== expv) begin miscompares++; $display("FAIL lb%0d_data: got %h expected %h", i, load_data, expv); end
         idle_inputs();
         tick();
         vectors++; if (load_data !== expv) begin miscompares++; $display("FAIL lb%0d_hold: got %h expected %h", i, load_data, expv); end
         $display("txn %s addr=00000102 load_data=%h", (i == 0) ? "LB " : "LBU", load_data);
      end
   endtask

   task automatic test_lhu_gnt_delay;
      int req_cycles;
      req_cycles = 0;
      mem_read = 1'b1; mem_load_type = 3'b100; addr = 32'h102; dmem_gnt = 1'b0;
      #1;
      vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL lhu_stall_accept: got %b expected 1", lsu_stall); end
      for (int c = 0; c < 4; c++) begin
         tick();
         if (dmem_req === 1'b1) req_cycles++;
         vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL lhu_stall_req%0d: got %b expected 1", c, lsu_stall); end
         if (c == 3) dmem_gnt = 1'b1;
      end
      vectors++; if (req_cycles != 4) begin miscompares++; $display("FAIL lhu_req_cycles: got %0d expected 4", req_cycles); end
      tick(); // WAIT_R
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL lhu_req_wait: got %b expected 0", dmem_req); end
      vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL lhu_stall_wait: got %b expected 1", lsu_stall); end
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF1234;
      tick(); // DONE
      vectors++; if (lsu_done !== 1'b1) begin miscompares++; $display("FAIL lhu_done: got %b expected 1", lsu_done); end
      vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL lhu_stall_done: got %b expected 0", lsu_stall); end
      vectors++; if (load_data !== 32'h0000BEEF) begin miscompares++; $display("FAIL lhu_data: got %h expected 0000beef", load_data); end
      idle_inputs();
      tick();
      $display("txn LHU addr=00000102 gnt+3 load_data=%h", load_data);
   endtask

   task automatic test_lw_misalign;
      mem_read = 1'b1; mem_load_type = 3'b010; addr = 32'h101; dmem_gnt = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
      #1;
      vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL mis_stall: got %b expected 0", lsu_stall); end
      tick();
      vectors++; if (misalign_err !== 1'b1) begin miscompares++; $display("FAIL mis_err: got %b expected 1", misalign_err); end
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req: got %b expected 0", dmem_req); end
      idle_inputs();
      tick();
      vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL mis_err_pulse: got %b expected 0", misalign_err); end
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL mis_req_after: got %b expected 0", dmem_req); end
      $display("txn LW addr=00000101 trapped");
`else
      #1;
      vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL mis_stall: got %b expected 1", lsu_stall); end
      tick(); // REQ with truncated address
      vectors++; if (dmem_addr !== 32'h100) begin miscompares++; $display("FAIL mis_addr: got %h expected 00000100", dmem_addr); end
      vectors++; if (misalign_err !== 1'b0) begin miscompares++; $display("FAIL mis_err: got %b expected 0", misalign_err); end
      tick(); // WAIT_R
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFEF00D;
      tick(); // DONE
      vectors++; if (load_data !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mis_data: got %h expected cafef00d", load_data); end
      vectors++; if (lsu_done !== 1'b1) begin miscompares++; $display("FAIL mis_done: got %b expected 1", lsu_done); end
      idle_inputs();
      tick();
      $display("txn LW addr=00000101 truncated load_data=%h", load_data);
`endif
   endtask

   task automatic test_reset_midflight;
      mem_read = 1'b1; mem_load_type = 3'b010; addr = 32'h200; dmem_gnt = 1'b1;
      tick(); // REQ
      tick(); // WAIT_R
      vectors++; if (lsu_stall !== 1'b1) begin miscompares++; $display("FAIL mid_stall_wait: got %b expected 1", lsu_stall); end
      rst = 1'b1; dmem_gnt = 1'b0;
      tick();
      rst = 1'b0;
      idle_inputs();
      dmem_rvalid = 1'b1; dmem_rdata = 32'h12345678; // late response
      #1;
      vectors++; if (load_data !== 32'h0) begin miscompares++; $display("FAIL mid_load_data: got %h expected 0", load_data); end
      vectors++; if (lsu_stall !== 1'b0) begin miscompares++; $display("FAIL mid_stall: got %b expected 0", lsu_stall); end
      vectors++; if (dmem_req !== 1'b0) begin miscompares++; $display("FAIL mid_req: got %b expected 0", dmem_req); end
      vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("FAIL mid_done: got %b expected 0", lsu_done); end
      tick();
      vectors++; if (lsu_done !== 1'b0) begin miscompares++; $display("FAIL mid_done_late: got %b expected 0", lsu_done); end
      vectors++; if (load_data !== 32'h0) begin miscompares++; $display("FAIL mid_load_data_late: got %h expected 0", load_data); end
      dmem_rvalid = 1'b0;
      tick();
      $display("txn LW addr=00000200 reset in WAIT_R, late rvalid");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_sw();
      test_def_ignored();
      test_sb_sh();
      test_lb_lbu();
      test_lhu_gnt_delay();
      test_lw_misalign();
      test_reset_midflight();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
